primogen_ctrl: RTL and testbench
================================

# primogen_ctrl

Sequencer for a single `primogen` prime-number generator instance. It paces prime generation from an internal tick divider or from single-step requests, and drives the `go` handshake with the mandatory one-cycle input-registration guard. It publishes each new prime with a valid pulse and a running index, and recovers from generator overflow or timeout by re-resetting the generator. It sits between board-level top files (LED/display logic) and `primogen`.

## Interface
- `WIDTH`, 16: width of prime values (matches primogen `res`).
- `DIV`, 12000000: tick period in `clk` cycles (≥2).
- `RST_CYCLES`, 15: cycles `pg_rst` is held during recovery (≥1).
- `TIMEOUT`, 65535: max cycles waiting for a result before forced recovery (≥2).
- `clk  in  1`  system clock.
- `rst  in  1`  reset, synchronous, active-high.
- `run  in  1`  1 = generate one prime per tick.
- `step  in  1`  single-cycle pulse: request one prime (honoured regardless of `run`).
- `pg_go  out  1`  to primogen `go`.
- `pg_rst  out  1`  to primogen `rst`.
- `pg_ready  in  1`  from primogen `ready`.
- `pg_error  in  1`  from primogen `error`.
- `pg_res  in  WIDTH`  from primogen `res`.
- `prime  out  WIDTH`  last published prime.
- `prime_valid  out  1`  one-cycle pulse when `prime` updates.
- `index  out  WIDTH`  count of primes published since last (re)start.
- `wrap  out  1`  one-cycle pulse on entering recovery.
- `busy  out  1`  high outside IDLE.

## Operation
- States: RESET_PG, IDLE, ISSUE, GUARD, WAIT.
- RESET_PG: `pg_rst`=1; counter runs RST_CYCLES cycles, then IDLE. Entered on `rst` and on every recovery.
- IDLE: when `trigger` && `pg_ready` -> ISSUE. `trigger` = pending-step flag, or `run` && tick.
- ISSUE: `pg_go`=1 for exactly one cycle; clears pending-step; -> GUARD.
- GUARD: one cycle, `pg_ready`/`pg_error` ignored (generator registers inputs); -> WAIT.
- WAIT: `pg_error` -> recovery (priority over ready); else `pg_ready` -> latch `prime`<=`pg_res`, pulse `prime_valid`, `index`+=1 (wraps mod 2^WIDTH), -> IDLE; else wait counter reaching TIMEOUT -> recovery.
- Recovery: pulse `wrap`, `index`<=0, `prime` holds value, -> RESET_PG.
- Step pending flag: one deep; set by `step` in any state, cleared only in ISSUE; extra steps while pending are dropped.
- Tick: free-running divider 0..DIV-1, tick on DIV-1; a tick arriving outside IDLE is lost (no queueing). Divider frozen and cleared while `rst`.
- `run` deasserted mid-WAIT: current result still published.
- Reset values: state RESET_PG, `pg_rst`=1, `pg_go`=0, `prime`=0, `prime_valid`=0, `index`=0, `wrap`=0, `busy`=1, pending=0, divider=0.

## Timing
- `rst` sampled high -> next cycle in RESET_PG; `rst` dominates all states.
- `pg_rst` high for RST_CYCLES cycles after reset release, then IDLE.
- Trigger seen in IDLE at cycle N -> `pg_go` high at N+1 (registered), GUARD N+2, WAIT from N+3.
- `pg_ready` sampled high in WAIT at cycle M -> `prime`, `index`, `prime_valid` visible at M+1; IDLE at M+1, earliest next `pg_go` at M+2.
- `pg_error` in WAIT at cycle M -> `wrap` pulse and `pg_rst` high from M+1.
- All outputs registered; no combinational path from `pg_*` inputs to outputs.

## Structure
- `primogen_defs.vh`: state encodings, default WIDTH.
- Sub-module `tick_gen` (DIV parameter, `clk`, `rst`, `tick` out): the divider; rest is one FSM module.

## Test plan
Bench uses a behavioural primogen model (result 3 cycles after `go`, sequence 2,3,5,7,…; error on programmable index). WIDTH=16, DIV=8, RST_CYCLES=4, TIMEOUT=20.
- Reset release: `pg_rst` high exactly 4 cycles, all outputs at reset values, `busy`=1 -> 0.
- `run`=1 for 40 cycles: `prime_valid` pulses with `prime`=2,3,5,7,11, `index`=1..5, pulses 8 cycles apart.
- `run`=0, `step` pulse: exactly one `pg_go`, one cycle after step; `prime`=2; two steps during WAIT -> only one further prime.
- Model asserts `pg_ready` during GUARD: ignored; result taken only from WAIT.
- Model errors on 4th prime: `wrap` pulse, `index`=0, `prime` holds 5, `pg_rst` 4 cycles, next publish `prime`=2 `index`=1.
- Model never answers: after 20 WAIT cycles `wrap` pulses and recovery runs; `rst` asserted mid-WAIT -> RESET_PG next cycle, `prime`=0.

Source files
------------

// File: rtl/primogen_ctrl_pkg.sv
// Shared definitions for the primogen sequencer: state encoding and default widths.
package primogen_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [2:0] {
        RESET_PG = 3'd0,
        IDLE     = 3'd1,
        ISSUE    = 3'd2,
        GUARD    = 3'd3,
        WAIT     = 3'd4
    } state_t;

endpackage

// File: rtl/primogen_ctrl_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
module tick_gen #(
    parameter int DIV = 12000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/primogen_ctrl.sv
// Sequencer for one primogen generator: paces requests, guards the go handshake,
// publishes primes with a running index and re-resets the generator on error/timeout.
module primogen_ctrl
    import primogen_ctrl_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int DIV        = 12000000,
    parameter int RST_CYCLES = 15,
    parameter int TIMEOUT    = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    output logic             pg_go,
    output logic             pg_rst,
    input  logic             pg_ready,
    input  logic             pg_error,
    input  logic [WIDTH-1:0] pg_res,
    output logic [WIDTH-1:0] prime,
    output logic             prime_valid,
    output logic [WIDTH-1:0] index,
    output logic             wrap,
    output logic             busy
);

    localparam int RCW = $clog2(RST_CYCLES + 1);
    localparam int TCW = $clog2(TIMEOUT + 1);
    localparam logic [RCW-1:0] RST_LAST  = RCW'(RST_CYCLES - 1);
    localparam logic [TCW-1:0] WAIT_LAST = TCW'(TIMEOUT - 1);

    state_t         state;
    logic           pending;
    logic           tick;
    logic [RCW-1:0] rst_cnt;
    logic [TCW-1:0] wait_cnt;

    tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // A step arriving in IDLE triggers immediately; otherwise it waits in the one-deep pending flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RESET_PG;
            pg_rst      <= 1'b1;
            pg_go       <= 1'b0;
            prime       <= '0;
            prime_valid <= 1'b0;
            index       <= '0;
            wrap        <= 1'b0;
            busy        <= 1'b1;
            pending     <= 1'b0;
            rst_cnt     <= '0;
            wait_cnt    <= '0;
        end else begin
            pg_go       <= 1'b0;
            prime_valid <= 1'b0;
            wrap        <= 1'b0;
            pending     <= pending | step;

            case (state)
                RESET_PG: begin
                    if (rst_cnt == RST_LAST) begin
                        state  <= IDLE;
                        pg_rst <= 1'b0;
                        busy   <= 1'b0;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end

                IDLE: begin
                    if ((pending | step | (run & tick)) && pg_ready) begin
                        state <= ISSUE;
                        pg_go <= 1'b1;
                        busy  <= 1'b1;
                    end
                end

                ISSUE: begin
                    pending <= step;
                    state   <= GUARD;
                end

                // The generator is still registering go here, so its status is stale.
                GUARD: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end

                WAIT: begin
                    if (pg_error || (!pg_ready && wait_cnt == WAIT_LAST)) begin
                        wrap    <= 1'b1;
                        index   <= '0;
                        pg_rst  <= 1'b1;
                        rst_cnt <= '0;
                        state   <= RESET_PG;
                    end else if (pg_ready) begin
                        prime       <= pg_res;
                        prime_valid <= 1'b1;
                        index       <= index + 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                default: begin
                    pg_rst  <= 1'b1;
                    busy    <= 1'b1;
                    rst_cnt <= '0;
                    state   <= RESET_PG;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_primogen_ctrl.sv
// Directed-plus-random bench for primogen_ctrl against a behavioural primogen model.
module tb_primogen_ctrl;

    localparam int WIDTH      = 16;
    localparam int DIV        = 8;
    localparam int RST_CYCLES = 4;
    localparam int TIMEOUT    = 20;
    localparam int RES_LAT    = 3;

    localparam int W_VALID = 0;
    localparam int W_WRAP  = 1;
    localparam int W_IDLE  = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             run = 1'b0;
    logic             step = 1'b0;
    logic             pg_go, pg_rst;
    logic             pg_ready = 1'b1;
    logic             pg_error = 1'b0;
    logic [WIDTH-1:0] pg_res = '0;
    logic [WIDTH-1:0] prime, index;
    logic             prime_valid, wrap, busy;

    int compared   = 0;
    int mismatched = 0;
    int exp_idx    = 0;

    int err_at    = 0;
    bit mute      = 1'b0;
    bit late_drop = 1'b0;
    int m_cnt     = 0;
    int m_k       = 0;
    bit m_drop    = 1'b0;

    primogen_ctrl #(
        .WIDTH(WIDTH), .DIV(DIV), .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .step(step),
        .pg_go(pg_go), .pg_rst(pg_rst), .pg_ready(pg_ready), .pg_error(pg_error),
        .pg_res(pg_res), .prime(prime), .prime_valid(prime_valid),
        .index(index), .wrap(wrap), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int nth_prime(input int n);
        int found;
        int c;
        bit is_p;
        found = 0;
        c = 1;
        while (found < n) begin
            c++;
            is_p = 1'b1;
            for (int d = 2; d * d <= c; d++)
                if (c % d == 0) is_p = 1'b0;
            if (is_p) found++;
        end
        return c;
    endfunction

    // Generator model: answers RES_LAT cycles after go, optionally late to drop ready, mute, or erroring.
    always @(posedge clk) begin
        if (pg_rst === 1'b1) begin
            pg_ready <= 1'b1;
            pg_error <= 1'b0;
            pg_res   <= '0;
            m_k      <= 0;
            m_cnt    <= 0;
            m_drop   <= 1'b0;
        end else if (pg_go === 1'b1) begin
            m_cnt <= RES_LAT;
            if (late_drop) m_drop <= 1'b1;
            else           pg_ready <= 1'b0;
        end else begin
            if (m_drop) begin
                pg_ready <= 1'b0;
                m_drop   <= 1'b0;
            end
            if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1 && !mute) begin
                    if (m_k + 1 == err_at) begin
                        pg_error <= 1'b1;
                    end else begin
                        pg_ready <= 1'b1;
                        pg_res   <= WIDTH'(nth_prime(m_k + 1));
                        m_k      <= m_k + 1;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s);
        run  = r;
        step = s;
        @(negedge clk);
    endtask

    function automatic logic watched(input int which);
        case (which)
            W_VALID: return prime_valid;
            W_WRAP:  return wrap;
            W_IDLE:  return !busy;
            default: return 1'b0;
        endcase
    endfunction

    task automatic waitFor(input string tag, input int which, input int limit, output int n);
        n = 0;
        while (watched(which) !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, watched(which), 1);
    endtask

    initial begin
        int n, gap, gos, pubs, rcount, ntx;

        // Reset state and pg_rst length after release.
        repeat (3) @(negedge clk);
        checkOutput("rst_pg_rst", pg_rst, 1);
        checkOutput("rst_pg_go", pg_go, 0);
        checkOutput("rst_prime", prime, 0);
        checkOutput("rst_valid", prime_valid, 0);
        checkOutput("rst_index", index, 0);
        checkOutput("rst_wrap", wrap, 0);
        checkOutput("rst_busy", busy, 1);
        rst = 1'b0;
        rcount = 0;
        while (pg_rst === 1'b1 && rcount < 50) begin
            rcount++;
            @(negedge clk);
        end
        checkOutput("rst_pg_rst_len", rcount, RST_CYCLES);
        checkOutput("rst_busy_low", busy, 0);

        // Free-running generation from the tick.
        gap = $urandom_range(1, 6);
        repeat (gap) @(negedge clk);
        run = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            waitFor("run_valid", W_VALID, 40, n);
            exp_idx++;
            checkOutput("run_prime", prime, nth_prime(exp_idx));
            checkOutput("run_index", index, exp_idx);
            if (i > 1) checkOutput("run_spacing", n + 1, DIV);
            if (i == 5) run = 1'b0;
            @(negedge clk);
        end

        // Single steps with random gaps.
        ntx = $urandom_range(2, 4);
        for (int t = 0; t < ntx; t++) begin
            gap = $urandom_range(1, 5);
            repeat (gap) @(negedge clk);
            applyStimulus(1'b0, 1'b1);
            checkOutput("step_go", pg_go, 1);
            applyStimulus(1'b0, 1'b0);
            checkOutput("step_go_once", pg_go, 0);
            waitFor("step_valid", W_VALID, 20, n);
            exp_idx++;
            checkOutput("step_prime", prime, nth_prime(exp_idx));
            checkOutput("step_index", index, exp_idx);
            @(negedge clk);
        end

        // Two steps landing in WAIT collapse into one further request.
        applyStimulus(1'b0, 1'b1);
        checkOutput("dbl_go", pg_go, 1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("dbl_busy_wait", busy, 1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        step = 1'b0;
        waitFor("dbl_valid", W_VALID, 20, n);
        exp_idx++;
        checkOutput("dbl_prime_first", prime, nth_prime(exp_idx));
        gos = 0;
        pubs = 0;
        repeat (30) begin
            @(negedge clk);
            gos += int'(pg_go);
            pubs += int'(prime_valid);
            if (prime_valid === 1'b1) begin
                exp_idx++;
                checkOutput("dbl_prime_next", prime, nth_prime(exp_idx));
            end
        end
        checkOutput("dbl_go_count", gos, 1);
        checkOutput("dbl_pub_count", pubs, 1);

        // Generator holds ready through GUARD; result must come from WAIT only.
        late_drop = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        applyStimulus(1'b0, 1'b1);
        checkOutput("guard_go", pg_go, 1);
        applyStimulus(1'b0, 1'b0);
        waitFor("guard_valid", W_VALID, 20, n);
        exp_idx++;
        checkOutput("guard_prime", prime, nth_prime(exp_idx));
        checkOutput("guard_index", index, exp_idx);
        checkOutput("guard_go_to_valid", n + 1, 5);
        late_drop = 1'b0;

        // Restart, then error on the 4th prime.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("err_rst_prime", prime, 0);
        rst = 1'b0;
        exp_idx = 0;
        err_at = 4;
        waitFor("err_idle", W_IDLE, 20, n);
        run = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            waitFor("err_valid", W_VALID, 40, n);
            exp_idx++;
            checkOutput("err_prime", prime, nth_prime(exp_idx));
            checkOutput("err_index", index, exp_idx);
            @(negedge clk);
        end
        waitFor("err_wrap", W_WRAP, 40, n);
        err_at = 0;
        exp_idx = 0;
        checkOutput("err_wrap_index", index, 0);
        checkOutput("err_wrap_prime", prime, 5);
        checkOutput("err_wrap_pg_rst", pg_rst, 1);
        @(negedge clk);
        checkOutput("err_wrap_pulse", wrap, 0);
        rcount = 1;
        while (pg_rst === 1'b1 && rcount < 50) begin
            rcount++;
            @(negedge clk);
        end
        checkOutput("err_pg_rst_len", rcount, RST_CYCLES);
        waitFor("err_next_valid", W_VALID, 40, n);
        run = 1'b0;
        exp_idx++;
        checkOutput("err_next_prime", prime, 2);
        checkOutput("err_next_index", index, 1);
        @(negedge clk);

        // Silent generator: timeout recovery, then reset while waiting.
        mute = 1'b1;
        waitFor("to_idle", W_IDLE, 20, n);
        applyStimulus(1'b0, 1'b1);
        checkOutput("to_go", pg_go, 1);
        step = 1'b0;
        waitFor("to_wrap", W_WRAP, 60, n);
        checkOutput("to_go_to_wrap", n, TIMEOUT + 2);
        checkOutput("to_index", index, 0);
        checkOutput("to_prime_hold", prime, 2);
        waitFor("to_idle2", W_IDLE, 20, n);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 0);
        applyStimulus(1'b0, 0);
        repeat ($urandom_range(1, 8)) @(negedge clk);
        checkOutput("mid_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_pg_rst", pg_rst, 1);
        checkOutput("mid_prime", prime, 0);
        checkOutput("mid_index", index, 0);
        checkOutput("mid_busy_rst", busy, 1);
        checkOutput("mid_wrap", wrap, 0);
        rst = 1'b0;
        mute = 1'b0;
        waitFor("mid_idle", W_IDLE, 20, n);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        waitFor("mid_valid", W_VALID, 20, n);
        checkOutput("mid_next_prime", prime, 2);
        checkOutput("mid_next_index", index, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
